// File: rtl/parking_gate_ctrl.sv
// Parking-lot gate controller.
// Grants one barrier at a time (exit has priority), holds it open for
// OPEN_CYCLES clocks, refuses entry when the lot is full with a pulsing
// deny, and tracks a registered full flag plus a sticky count-error flag.
module parking_gate_ctrl #(
  parameter int CAPACITY    = 8,
  parameter int OPEN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num,
  input  logic       entry_req,
  input  logic       exit_req,
  output logic       entry_open,
  output logic       exit_open,
  output logic       full,
  output logic       deny,
  output logic       cnt_err
);

  // Capacity and timer reload value, both sized to the 8-bit compare/timer path.
  localparam logic [7:0] CAP_W     = 8'(CAPACITY);
  localparam logic [7:0] TIMER_LD  = 8'(OPEN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  timer_r;
  logic [7:0]  num_w_s;
  logic        at_cap_s;
  logic        over_cap_s;

  // Occupancy comparisons; a count above capacity also counts as full.
  always_comb begin
    num_w_s    = {4'd0, num};
    at_cap_s   = (num_w_s >= CAP_W);
    over_cap_s = (num_w_s >  CAP_W);
  end

  // Gate FSM with down-timer; all barrier and deny outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      timer_r    <= 8'd0;
      entry_open <= 1'b0;
      exit_open  <= 1'b0;
      deny       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (exit_req) begin
            // Exit wins over a simultaneous entry request; no deny in this cycle.
            state_r    <= EXIT_OPEN;
            timer_r    <= TIMER_LD;
            exit_open  <= 1'b1;
            entry_open <= 1'b0;
            deny       <= 1'b0;
          end else if (entry_req && !at_cap_s) begin
            state_r    <= ENTRY_OPEN;
            timer_r    <= TIMER_LD;
            entry_open <= 1'b1;
            exit_open  <= 1'b0;
            deny       <= 1'b0;
          end else if (entry_req) begin
            // Refused entry: toggling yields pulse, gap, pulse while the request is held.
            state_r    <= IDLE;
            timer_r    <= 8'd0;
            entry_open <= 1'b0;
            exit_open  <= 1'b0;
            deny       <= ~deny;
          end else begin
            state_r    <= IDLE;
            timer_r    <= 8'd0;
            entry_open <= 1'b0;
            exit_open  <= 1'b0;
            deny       <= 1'b0;
          end
        end
        ENTRY_OPEN, EXIT_OPEN: begin
          // Requests are ignored while a gate is open; the grant runs to expiry.
          deny <= 1'b0;
          if (timer_r == 8'd0) begin
            state_r    <= IDLE;
            entry_open <= 1'b0;
            exit_open  <= 1'b0;
          end else begin
            timer_r    <= timer_r - 8'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          timer_r    <= 8'd0;
          entry_open <= 1'b0;
          exit_open  <= 1'b0;
          deny       <= 1'b0;
        end
      endcase
    end
  end

  // Occupancy status: full follows num with one cycle of latency, cnt_err is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 1'b0;
      cnt_err <= 1'b0;
    end else begin
      full    <= at_cap_s;
      cnt_err <= cnt_err | over_cap_s;
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: a behavioural model of the
// gate rules checked every cycle, plus directed scenarios with literal
// expectations.
module tb_parking_gate_ctrl;

  localparam int CAP  = 8;
  localparam int OPEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] num = 4'd0;
  logic       entry_req = 1'b0;
  logic       exit_req  = 1'b0;
  logic       entry_open, exit_open, full, deny, cnt_err;

  int checks   = 0;
  int failures = 0;

  parking_gate_ctrl #(.CAPACITY(CAP), .OPEN_CYCLES(OPEN)) dut (
    .clk(clk), .rst(rst), .num(num), .entry_req(entry_req), .exit_req(exit_req),
    .entry_open(entry_open), .exit_open(exit_open), .full(full),
    .deny(deny), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: which gate is open and how many open cycles remain.
  int   m_gate = 0;   // 0 none, 1 entry, 2 exit
  int   m_left = 0;
  logic m_deny = 1'b0;
  logic m_full = 1'b0;
  logic m_err  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_gate = 0; m_left = 0; m_deny = 1'b0; m_full = 1'b0; m_err = 1'b0;
    end else begin
      m_full = (int'(num) >= CAP);
      if (int'(num) > CAP) m_err = 1'b1;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) m_gate = 0;
        m_deny = 1'b0;
      end else if (exit_req) begin
        m_gate = 2; m_left = OPEN; m_deny = 1'b0;
      end else if (entry_req && int'(num) < CAP) begin
        m_gate = 1; m_left = OPEN; m_deny = 1'b0;
      end else if (entry_req) begin
        m_deny = !m_deny;
      end else begin
        m_deny = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("entry_open", {15'd0, entry_open}, {15'd0, (m_gate == 1)});
    chk("exit_open",  {15'd0, exit_open},  {15'd0, (m_gate == 2)});
    chk("deny",       {15'd0, deny},       {15'd0, m_deny});
    chk("full",       {15'd0, full},       {15'd0, m_full});
    chk("cnt_err",    {15'd0, cnt_err},    {15'd0, m_err});
    chk("mutex",      {15'd0, (entry_open & exit_open)}, 16'd0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [5:0] dvec;
  logic [9:0] evec, xvec;
  int         ocnt, dcnt;

  initial begin
    // Reset state.
    step(); step();
    chk("rst_outputs", {11'd0, entry_open, exit_open, full, deny, cnt_err}, 16'd0);
    rst = 1'b0;
    step();

    // Single entry grant: open exactly OPEN cycles, no deny.
    num = 4'd3; entry_req = 1'b1;
    ocnt = 0; dcnt = 0;
    step();
    entry_req = 1'b0;
    if (entry_open) ocnt++;
    for (int i = 0; i < 7; i++) begin
      step();
      if (entry_open) ocnt++;
      if (deny) dcnt++;
    end
    chk("entry_len", 16'(ocnt), 16'd4);
    chk("entry_nodeny", 16'(dcnt), 16'd0);

    // Full lot: held entry gives pulse, gap, pulse.
    num = 4'd8;
    step(); step();
    chk("full_set", {15'd0, full}, 16'd1);
    entry_req = 1'b1;
    ocnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      dvec[i] = deny;
      if (entry_open) ocnt++;
    end
    entry_req = 1'b0;
    chk("deny_pattern", {10'd0, dvec}, 16'h0015);
    chk("full_no_entry", 16'(ocnt), 16'd0);
    step(); step();

    // Simultaneous requests: exit first, then the held entry one cycle after close.
    num = 4'd5;
    step();
    entry_req = 1'b1; exit_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) exit_req = 1'b0;
      xvec[i] = exit_open;
      evec[i] = entry_open;
      if (i == 0) chk("prio_nodeny", {15'd0, deny}, 16'd0);
    end
    entry_req = 1'b0;
    chk("prio_exit", {6'd0, xvec}, 16'h000F);
    chk("prio_entry", {6'd0, evec}, 16'h01E0);
    step(); step();

    // Asynchronous reset in the middle of an entry grant.
    num = 4'd3; entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    step();
    chk("pre_rst_open", {15'd0, entry_open}, 16'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst", {12'd0, entry_open, exit_open, deny, full}, 16'd0);
    step();
    #1 rst = 1'b0;
    ocnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (entry_open | exit_open | deny) ocnt++;
    end
    chk("no_resume", 16'(ocnt), 16'd0);

    // Over-capacity count: sticky error, full follows num.
    num = 4'd9;
    step();
    chk("over_full", {14'd0, full, cnt_err}, 16'd3);
    num = 4'd2;
    step();
    chk("err_sticky", {14'd0, full, cnt_err}, 16'd1);
    step(); step();
    chk("err_hold", {15'd0, cnt_err}, 16'd1);

    // Lot fills while the entry gate is open: grant completes, next entry denied.
    num = 4'd7; entry_req = 1'b1;
    ocnt = 0;
    step();
    entry_req = 1'b0; num = 4'd8;
    if (entry_open) ocnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (entry_open) ocnt++;
    end
    chk("fill_open_len", 16'(ocnt), 16'd4);
    entry_req = 1'b1;
    step();
    chk("fill_deny", {14'd0, deny, entry_open}, 16'd2);
    entry_req = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
